// File: rtl/tx_protocol_arbiter_pkg.sv
// Shared encodings for the transmit arbiter and the network top-level.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tx_protocol_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_START = 2'd2,
        ST_BUSY  = 2'd3
    } state_e;

    localparam int CH_ARP  = 0;
    localparam int CH_ICMP = 1;
    localparam int CH_DHCP = 2;
    localparam int CH_UDP  = 3;

    function automatic int wrap_inc(input int idx, input int num);
        return (idx + 1 >= num) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/tx_protocol_arbiter_if.sv
// Bundle between the protocol engines / send chain and the transmit arbiter.
// Latency: n/a (wiring only).
// Backpressure: tx_busy from the send chain holds the arbiter off.
interface tx_protocol_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = $clog2(NUM_CH)
);
    logic              enable;
    logic [NUM_CH-1:0] tx_request;
    logic              tx_busy;
    logic              tx_start;
    logic [NUM_CH-1:0] tx_grant;
    logic [ID_W-1:0]   tx_channel;
    logic              timeout_pulse;

    modport master (
        input  enable, tx_request, tx_busy,
        output tx_start, tx_grant, tx_channel, timeout_pulse
    );

    modport slave (
        output enable, tx_request, tx_busy,
        input  tx_start, tx_grant, tx_channel, timeout_pulse
    );
endinterface

// File: rtl/tx_protocol_arbiter_rr_pick.sv
// Winner selection: fixed lowest-index or round-robin from ptr via a double-width find-first.
// Latency: combinational.
// Backpressure: none; the caller decides when to use the result.
module tx_protocol_arbiter_rr_pick #(
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = 0,
    parameter int ID_W    = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] request,
    input  logic [ID_W-1:0]   ptr,
    output logic              found,
    output logic [NUM_CH-1:0] onehot,
    output logic [ID_W-1:0]   index
);
    logic [NUM_CH-1:0]   mask;
    logic [2*NUM_CH-1:0] dbl;

    // Lower half holds requests at/above ptr, upper half all requests, so the first
    // set bit is the round-robin winner including the wrap back to channel 0.
    always_comb begin
        mask   = '1;
        found  = 1'b0;
        index  = '0;
        onehot = '0;
        if (RR_MODE != 0) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mask[i] = (ID_W'(i) >= ptr);
            end
        end
        dbl = {request, request & mask};
        for (int i = 0; i < 2 * NUM_CH; i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                index = ID_W'(i % NUM_CH);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            onehot[i] = found && (index == ID_W'(i));
        end
    end

endmodule

// File: rtl/tx_protocol_arbiter.sv
// Grants the single transmit path to one of NUM_CH protocol sources, with start watchdog.
// Latency: request in cycle n -> grant n+1 -> tx_start n+2.
// Backpressure: tx_busy in IDLE blocks arbitration; a granted frame holds until tx_busy falls.
module tx_protocol_arbiter
    import tx_protocol_arbiter_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 4096,
    parameter int ID_W    = $clog2(NUM_CH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    tx_protocol_arbiter_if.master bus
);
    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e            state;
    state_e            state_nxt;
    logic [WD_W-1:0]   wd_cnt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   channel_q;
    logic [NUM_CH-1:0] grant_q;
    logic              timeout_q;

    logic              pick_found;
    logic [NUM_CH-1:0] pick_onehot;
    logic [ID_W-1:0]   pick_index;

    logic              load_grant;
    logic              release_grant;
    logic              wd_expire;

    tx_protocol_arbiter_rr_pick #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE),
        .ID_W    (ID_W)
    ) u_pick (
        .request (bus.tx_request),
        .ptr     (rr_ptr),
        .found   (pick_found),
        .onehot  (pick_onehot),
        .index   (pick_index)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // tx_busy is checked before the watchdog so a late busy never produces a timeout.
    always_comb begin
        state_nxt     = state;
        load_grant    = 1'b0;
        release_grant = 1'b0;
        wd_expire     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.enable && !bus.tx_busy && pick_found) begin
                    load_grant = 1'b1;
                    state_nxt  = ST_READY;
                end
            end
            ST_READY: begin
                state_nxt = ST_START;
            end
            ST_START: begin
                if (bus.tx_busy) begin
                    state_nxt = ST_BUSY;
                end else if (wd_cnt == WD_LAST) begin
                    wd_expire     = 1'b1;
                    release_grant = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!bus.tx_busy) begin
                    release_grant = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt    <= '0;
            grant_q   <= '0;
            channel_q <= '0;
            rr_ptr    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_expire;
            if (state == ST_START && state_nxt == ST_START) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (load_grant) begin
                grant_q   <= pick_onehot;
                channel_q <= pick_index;
            end else if (release_grant) begin
                grant_q   <= '0;
                channel_q <= '0;
                rr_ptr    <= ID_W'(wrap_inc(int'(channel_q), NUM_CH));
            end
        end
    end

    assign bus.tx_start      = (state == ST_START);
    assign bus.tx_grant      = grant_q;
    assign bus.tx_channel    = channel_q;
    assign bus.timeout_pulse = timeout_q;

endmodule

// File: tb/tb_tx_protocol_arbiter.sv
// Bench for the transmit arbiter: fixed-priority instance driven from a vector table,
// round-robin instance checked through a queue of expected channels.
module tb_tx_protocol_arbiter;
    import tx_protocol_arbiter_pkg::*;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    int   sb[$];

    tx_protocol_arbiter_if #(.NUM_CH(4)) if_f ();
    tx_protocol_arbiter_if #(.NUM_CH(4)) if_r ();

    tx_protocol_arbiter #(.NUM_CH(4), .RR_MODE(0), .TIMEOUT(16)) dut_f (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if_f.master)
    );

    tx_protocol_arbiter #(.NUM_CH(4), .RR_MODE(1), .TIMEOUT(16)) dut_r (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if_r.master)
    );

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic       busy;
        logic       start;
        logic [3:0] grant;
        logic [1:0] ch;
        logic       pulse;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 100000", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] obs_f();
        return {24'd0, if_f.tx_start, if_f.tx_grant, if_f.tx_channel, if_f.timeout_pulse};
    endfunction

    function automatic logic [31:0] obs_r();
        return {24'd0, if_r.tx_start, if_r.tx_grant, if_r.tx_channel, if_r.timeout_pulse};
    endfunction

    task automatic wait_start(input bit sel_r, input string name);
        int n;
        n = 0;
        while (n < 64 && !(sel_r ? if_r.tx_start : if_f.tx_start)) begin
            step();
            n++;
        end
        check(name, 32'(sel_r ? if_r.tx_start : if_f.tx_start), 32'd1);
    endtask

    initial begin
        int exp;
        int n;
        int bad;

        n_checks = 0;
        n_fail   = 0;

        // en, req, busy | start, grant, ch, pulse
        tbl[0]  = '{1'b1, 4'b1010, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0010, 2'(CH_ICMP), 1'b0};
        tbl[2]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0010, 2'(CH_ICMP), 1'b0};
        tbl[3]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0010, 2'(CH_ICMP), 1'b0};
        tbl[4]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0010, 2'(CH_ICMP), 1'b0};
        tbl[5]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 4'b0010, 2'(CH_ICMP), 1'b0};
        tbl[6]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0010, 2'(CH_ICMP), 1'b0};
        tbl[7]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0010, 2'(CH_ICMP), 1'b0};
        tbl[8]  = '{1'b1, 4'b1100, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[9]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'(CH_DHCP), 1'b0};
        tbl[10] = '{1'b1, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'(CH_DHCP), 1'b0};
        tbl[11] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'(CH_DHCP), 1'b0};
        tbl[12] = '{1'b1, 4'b1001, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[13] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 2'(CH_ARP), 1'b0};
        tbl[14] = '{1'b1, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'(CH_ARP), 1'b0};
        tbl[15] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 2'(CH_ARP), 1'b0};
        tbl[16] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};

        if_f.enable = 1'b0; if_f.tx_request = '0; if_f.tx_busy = 1'b0;
        if_r.enable = 1'b0; if_r.tx_request = '0; if_r.tx_busy = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_fixed", obs_f(), 32'd0);
        check("reset_rr", obs_r(), 32'd0);
        reset_n = 1'b1;
        step();

        // Fixed priority: latency, request drop after grant, immediate busy, lowest index wins.
        for (int i = 0; i < NV; i++) begin
            if_f.enable     = tbl[i].en;
            if_f.tx_request = tbl[i].req;
            if_f.tx_busy    = tbl[i].busy;
            #1;
            check($sformatf("vec%0d", i), obs_f(),
                  {24'd0, tbl[i].start, tbl[i].grant, tbl[i].ch, tbl[i].pulse});
            @(posedge clock);
            #1;
        end

        // Enable gate holds off a pending request.
        if_f.enable = 1'b0;
        if_f.tx_request = 4'b0001;
        bad = 0;
        repeat (100) begin
            step();
            if (if_f.tx_grant != 4'b0000 || if_f.tx_start) bad++;
        end
        check("enable_gate", 32'(bad), 32'd0);
        if_f.enable = 1'b1;
        step();
        check("enable_grant", 32'(if_f.tx_grant), 32'b0001);
        check("enable_channel", 32'(if_f.tx_channel), 32'(CH_ARP));
        if_f.tx_request = '0;
        wait_start(1'b0, "enable_start");
        if_f.tx_busy = 1'b1; step();
        if_f.tx_busy = 1'b0; step();

        // Foreign frame in flight blocks arbitration.
        if_f.tx_busy = 1'b1;
        if_f.tx_request = 4'b0100;
        bad = 0;
        repeat (20) begin
            step();
            if (if_f.tx_grant != 4'b0000) bad++;
        end
        check("busy_block", 32'(bad), 32'd0);
        if_f.tx_busy = 1'b0;
        step();
        check("busy_release_grant", 32'(if_f.tx_grant), 32'b0100);
        check("busy_release_channel", 32'(if_f.tx_channel), 32'(CH_DHCP));
        if_f.tx_request = '0;
        wait_start(1'b0, "busy_release_start");
        if_f.tx_busy = 1'b1; step();
        if_f.tx_busy = 1'b0; step();

        // Round robin with all channels requesting.
        if_r.enable = 1'b1;
        if_r.tx_request = 4'b1111;
        for (int k = 0; k < 5; k++) sb.push_back(k % 4);
        for (int k = 0; k < 5; k++) begin
            wait_start(1'b1, $sformatf("rr_start%0d", k));
            exp = sb.pop_front();
            check($sformatf("rr_channel%0d", k), 32'(if_r.tx_channel), 32'(exp));
            check($sformatf("rr_grant%0d", k), 32'(if_r.tx_grant), 32'(1) << exp);
            if_r.tx_busy = 1'b1;
            repeat (3) step();
            if (k == 4) if_r.tx_request = '0;
            if_r.tx_busy = 1'b0;
            step();
        end

        // Watchdog: pointer now at 1, channel 1 times out, channel 2 follows.
        sb.push_back(CH_ICMP);
        sb.push_back(CH_DHCP);
        if_r.tx_request = 4'b1111;
        wait_start(1'b1, "to_start");
        exp = sb.pop_front();
        check("to_channel", 32'(if_r.tx_channel), 32'(exp));
        n = 0;
        while (if_r.tx_start && n < 40) begin
            n++;
            step();
        end
        check("to_start_cycles", 32'(n), 32'd16);
        check("to_pulse", 32'(if_r.timeout_pulse), 32'd1);
        check("to_grant_clear", 32'(if_r.tx_grant), 32'd0);
        step();
        check("to_pulse_once", 32'(if_r.timeout_pulse), 32'd0);
        exp = sb.pop_front();
        check("to_next_channel", 32'(if_r.tx_channel), 32'(exp));
        check("to_next_grant", 32'(if_r.tx_grant), 32'(1) << exp);
        if_r.tx_request = '0;
        wait_start(1'b1, "to_next_start");
        if_r.tx_busy = 1'b1; step();
        if_r.tx_busy = 1'b0; step();

        // Reset mid-frame, then pointer back at 0.
        sb.push_back(CH_UDP);
        if_r.tx_request = 4'b1111;
        wait_start(1'b1, "rst_start");
        exp = sb.pop_front();
        check("rst_pre_channel", 32'(if_r.tx_channel), 32'(exp));
        if_r.tx_busy = 1'b1;
        step();
        check("rst_busy_grant", 32'(if_r.tx_grant), 32'b1000);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_outputs", obs_r(), 32'd0);
        #2;
        if_r.tx_busy = 1'b0;
        reset_n = 1'b1;
        sb.push_back(CH_ARP);
        @(posedge clock);
        #1;
        exp = sb.pop_front();
        check("rst_first_grant", 32'(if_r.tx_grant), 32'(1) << exp);
        check("rst_first_channel", 32'(if_r.tx_channel), 32'(exp));
        if_r.tx_request = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
